// File: rtl/computer_pkg.sv
// Shared encodings for the 8-bit two-register core: opcodes, ALU operations
// and ALU operand-B source selects.
package computer_pkg;

   localparam int unsigned INSTR_W = 15;

   localparam logic [6:0] OP_MOV_A_B   = 7'h00;
   localparam logic [6:0] OP_MOV_B_A   = 7'h01;
   localparam logic [6:0] OP_MOV_A_LIT = 7'h02;
   localparam logic [6:0] OP_MOV_B_LIT = 7'h03;
   localparam logic [6:0] OP_ADD_A_B   = 7'h04;
   localparam logic [6:0] OP_ADD_B_A   = 7'h05;
   localparam logic [6:0] OP_ADD_A_LIT = 7'h06;
   localparam logic [6:0] OP_SUB_A_B   = 7'h07;
   localparam logic [6:0] OP_AND_A_B   = 7'h08;
   localparam logic [6:0] OP_OR_A_B    = 7'h09;
   localparam logic [6:0] OP_XOR_A_B   = 7'h0A;
   localparam logic [6:0] OP_NOT_A     = 7'h0B;
   localparam logic [6:0] OP_SHL_A     = 7'h0C;
   localparam logic [6:0] OP_SHR_A     = 7'h0D;
   localparam logic [6:0] OP_MOV_A_DIR = 7'h0E;
   localparam logic [6:0] OP_MOV_DIR_A = 7'h0F;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b110;
   localparam logic [2:0] ALU_SHR = 3'b111;

   localparam logic [1:0] SELB_REGB = 2'b00;
   localparam logic [1:0] SELB_REGA = 2'b01;
   localparam logic [1:0] SELB_LIT  = 2'b10;
   localparam logic [1:0] SELB_MEM  = 2'b11;

endpackage

// File: rtl/computer_alu.sv
// Combinational 8-bit ALU; every result is truncated to 8 bits.
module computer_alu
   import computer_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   output logic [7:0] y
);

   always_comb begin
      y = a + b;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_NOT: y = ~a;
         ALU_SHL: y = {a[6:0], 1'b0};
         ALU_SHR: y = {1'b0, a[7:1]};
         default: y = a + b;
      endcase
   end

endmodule

// File: rtl/computer_decoder.sv
// Combinational opcode decoder; unlisted opcodes leave every enable low (NOP).
module computer_decoder
   import computer_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       LA,
   output logic       LB,
   output logic       wbSel,
   output logic       mem_we,
   output logic       selA,
   output logic [1:0] selB,
   output logic       selData,
   output logic [2:0] alu_op
);

   always_comb begin
      LA      = 1'b0;
      LB      = 1'b0;
      wbSel   = 1'b0;
      mem_we  = 1'b0;
      selA    = 1'b0;
      selB    = SELB_REGB;
      // Every memory opcode addresses by literal; regB-indirect stays unused.
      selData = 1'b0;
      alu_op  = ALU_ADD;
      case (opcode)
         OP_MOV_A_B:   begin selA = 1'b1; LA = 1'b1; end
         OP_MOV_B_A:   begin selA = 1'b1; selB = SELB_REGA; LB = 1'b1; end
         OP_MOV_A_LIT: begin wbSel = 1'b1; LA = 1'b1; end
         OP_MOV_B_LIT: begin wbSel = 1'b1; LB = 1'b1; end
         OP_ADD_A_B:   LA = 1'b1;
         OP_ADD_B_A:   LB = 1'b1;
         OP_ADD_A_LIT: begin selB = SELB_LIT; LA = 1'b1; end
         OP_SUB_A_B:   begin alu_op = ALU_SUB; LA = 1'b1; end
         OP_AND_A_B:   begin alu_op = ALU_AND; LA = 1'b1; end
         OP_OR_A_B:    begin alu_op = ALU_OR;  LA = 1'b1; end
         OP_XOR_A_B:   begin alu_op = ALU_XOR; LA = 1'b1; end
         OP_NOT_A:     begin alu_op = ALU_NOT; LA = 1'b1; end
         OP_SHL_A:     begin alu_op = ALU_SHL; LA = 1'b1; end
         OP_SHR_A:     begin alu_op = ALU_SHR; LA = 1'b1; end
         OP_MOV_A_DIR: begin selA = 1'b1; selB = SELB_MEM; LA = 1'b1; end
         OP_MOV_DIR_A: mem_we = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/computer_dmem.sv
// 256 x 8 data memory: combinational read, write on the rising edge, never cleared.
module computer_dmem (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] mem [0:255];

   // Reset only suppresses the write; contents survive it.
   always_ff @(posedge clk) begin
      if (rst_n && we)
         mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/computer_imem.sv
// 256 x 15-bit instruction store: combinational fetch plus a clocked program-load port.
module computer_imem (
   input  logic        clk,
   input  logic        we,
   input  logic [7:0]  waddr,
   input  logic [14:0] wdata,
   input  logic [7:0]  addr,
   output logic [14:0] data
);

   logic [14:0] mem [0:255];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign data = mem[addr];

endmodule

// File: rtl/reg8.sv
// 8-bit load-enabled register with synchronous active-low clear; powers up at 0.
module reg8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] in,
   output logic [7:0] out
);

   logic [7:0] q = 8'd0;

   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= 8'd0;
      else if (load)
         q <= in;
   end

   assign out = q;

endmodule

// File: rtl/computer_core.sv
// Single-cycle 8-bit core: fetch from IM at PC, decode, execute and write back
// on one rising edge; PC then advances by 1 and wraps at 256.
module computer_core
   import computer_pkg::*;
(
   input  logic clk,
   input  logic rst_n
);

   logic [7:0]         pc_out_bus = 8'd0;
   logic [INSTR_W-1:0] instr;
   logic [6:0]         opcode;
   logic [7:0]         literal;
   logic               LA, LB, wbSel, mem_we, selA, selData;
   logic [1:0]         selB;
   logic [2:0]         alu_op;
   logic [7:0]         alu_a, alu_b, alu_out_bus, wb_data;
   logic [7:0]         regA_out_bus, regB_out_bus;
   logic [7:0]         dm_addr, dm_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n)
         pc_out_bus <= 8'd0;
      else
         pc_out_bus <= pc_out_bus + 8'd1;
   end

   // The load port is left idle; programs are placed in IM before run time.
   computer_imem IM (
      .clk   (clk),
      .we    (1'b0),
      .waddr (8'd0),
      .wdata (15'd0),
      .addr  (pc_out_bus),
      .data  (instr)
   );

   assign opcode  = instr[14:8];
   assign literal = instr[7:0];

   computer_decoder DEC (
      .opcode  (opcode),
      .LA      (LA),
      .LB      (LB),
      .wbSel   (wbSel),
      .mem_we  (mem_we),
      .selA    (selA),
      .selB    (selB),
      .selData (selData),
      .alu_op  (alu_op)
   );

   assign dm_addr = selData ? regB_out_bus : literal;

   computer_dmem DM (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .addr  (dm_addr),
      .wdata (regA_out_bus),
      .rdata (dm_rdata)
   );

   assign alu_a = selA ? 8'd0 : regA_out_bus;

   always_comb begin
      alu_b = regB_out_bus;
      case (selB)
         SELB_REGB: alu_b = regB_out_bus;
         SELB_REGA: alu_b = regA_out_bus;
         SELB_LIT:  alu_b = literal;
         SELB_MEM:  alu_b = dm_rdata;
         default:   alu_b = regB_out_bus;
      endcase
   end

   computer_alu ALU (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .y  (alu_out_bus)
   );

   assign wb_data = wbSel ? literal : alu_out_bus;

   reg8 regA (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (LA),
      .in    (wb_data),
      .out   (regA_out_bus)
   );

   reg8 regB (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (LB),
      .in    (wb_data),
      .out   (regB_out_bus)
   );

endmodule

// File: tb/tb_computer_core.sv
// Bench for computer_core: directed programs, a per-opcode vector table, and
// random programs checked against an instruction-level model of the machine.
module tb_computer_core;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   logic [14:0] prog [0:255];
   logic [14:0] m_im [0:255];
   logic [7:0]  m_dm [0:255];
   logic [7:0]  m_a, m_b, m_pc;
   logic [23:0] exp_q [$];

   typedef struct packed {
      logic [14:0] instr;
      logic [7:0]  a_in;
      logic [7:0]  b_in;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
   } vec_t;

   vec_t vecs [0:15];

   computer_core dut (
      .clk   (clk),
      .rst_n (rst_n)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [14:0] ins(input logic [6:0] op, input logic [7:0] lit);
      return {op, lit};
   endfunction

   function automatic vec_t mkv(input logic [6:0] op, input logic [7:0] lit,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] ea, input logic [7:0] eb);
      return {ins(op, lit), a, b, ea, eb};
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) prog[i] = ins(7'h7F, 8'(i));
   endtask

   task automatic load_im();
      for (int i = 0; i < 256; i++) begin
         dut.IM.mem[i] = prog[i];
         m_im[i] = prog[i];
      end
   endtask

   task automatic clear_dm();
      for (int i = 0; i < 256; i++) begin
         dut.DM.mem[i] = 8'd0;
         m_dm[i] = 8'd0;
      end
   endtask

   task automatic start_prog();
      rst_n = 1'b0;
      load_im();
      step();
      rst_n = 1'b1;
      m_a = 8'd0;
      m_b = 8'd0;
      m_pc = 8'd0;
   endtask

   // Instruction-level reference: the architectural effect of one instruction.
   task automatic model_step();
      logic [14:0] w;
      int a, b, lit;
      w = m_im[m_pc];
      a = int'(m_a);
      b = int'(m_b);
      lit = int'(w[7:0]);
      case (int'(w[14:8]))
         0:  m_a = m_b;
         1:  m_b = m_a;
         2:  m_a = w[7:0];
         3:  m_b = w[7:0];
         4:  m_a = 8'((a + b) % 256);
         5:  m_b = 8'((a + b) % 256);
         6:  m_a = 8'((a + lit) % 256);
         7:  m_a = 8'((a - b + 256) % 256);
         8:  m_a = m_a & m_b;
         9:  m_a = m_a | m_b;
         10: m_a = m_a ^ m_b;
         11: m_a = 8'(255 - a);
         12: m_a = 8'((a * 2) % 256);
         13: m_a = 8'(a / 2);
         14: m_a = m_dm[w[7:0]];
         15: m_dm[w[7:0]] = m_a;
         default: ;
      endcase
      m_pc = 8'((int'(m_pc) + 1) % 256);
   endtask

   initial begin
      logic [7:0] dm_dirty;
      logic [23:0] e;
      int r;
      logic [6:0] op;
      logic [7:0] lit;

      vecs[0]  = mkv(7'h00, 8'h00, 8'd11,  8'd22,  8'd22,  8'd22);
      vecs[1]  = mkv(7'h01, 8'h00, 8'd11,  8'd22,  8'd11,  8'd11);
      vecs[2]  = mkv(7'h02, 8'h99, 8'd11,  8'd22,  8'h99,  8'd22);
      vecs[3]  = mkv(7'h03, 8'h5A, 8'd11,  8'd22,  8'd11,  8'h5A);
      vecs[4]  = mkv(7'h04, 8'h00, 8'd200, 8'd100, 8'd44,  8'd100);
      vecs[5]  = mkv(7'h05, 8'h00, 8'd200, 8'd100, 8'd200, 8'd44);
      vecs[6]  = mkv(7'h06, 8'h10, 8'hF8,  8'd1,   8'h08,  8'd1);
      vecs[7]  = mkv(7'h07, 8'h00, 8'd3,   8'd5,   8'hFE,  8'd5);
      vecs[8]  = mkv(7'h08, 8'h00, 8'hF0,  8'h3C,  8'h30,  8'h3C);
      vecs[9]  = mkv(7'h09, 8'h00, 8'hF0,  8'h3C,  8'hFC,  8'h3C);
      vecs[10] = mkv(7'h0A, 8'h00, 8'hF0,  8'h3C,  8'hCC,  8'h3C);
      vecs[11] = mkv(7'h0B, 8'h00, 8'h0F,  8'h77,  8'hF0,  8'h77);
      vecs[12] = mkv(7'h0C, 8'h00, 8'h81,  8'h01,  8'h02,  8'h01);
      vecs[13] = mkv(7'h0D, 8'h00, 8'h81,  8'h01,  8'h40,  8'h01);
      vecs[14] = mkv(7'h7F, 8'h12, 8'h33,  8'h44,  8'h33,  8'h44);
      vecs[15] = mkv(7'h10, 8'hAB, 8'h33,  8'h44,  8'h33,  8'h44);

      // Power-up run with rst_n high from time zero.
      fill_nop();
      prog[0] = ins(7'h02, 8'd42);
      prog[1] = ins(7'h03, 8'd123);
      load_im();
      clear_dm();
      #1;
      check8("powerup_pc", dut.pc_out_bus, 8'd0);
      check8("powerup_a", dut.regA.out, 8'd0);
      check8("powerup_b", dut.regB.out, 8'd0);
      step();
      check8("mov_lit_e1_a", dut.regA.out, 8'd42);
      step();
      check8("mov_lit_e2_b", dut.regB.out, 8'd123);
      check8("mov_lit_e2_pc", dut.pc_out_bus, 8'd2);

      // MOV A,2; MOV B,3; ADD A,B
      fill_nop();
      prog[0] = ins(7'h02, 8'd2);
      prog[1] = ins(7'h03, 8'd3);
      prog[2] = ins(7'h04, 8'd0);
      start_prog();
      check8("reset_pc", dut.pc_out_bus, 8'd0);
      check8("reset_a", dut.regA.out, 8'd0);
      step();
      check8("add_e1_a", dut.regA.out, 8'd2);
      step();
      check8("add_e2_b", dut.regB.out, 8'd3);
      step();
      check8("add_e3_a", dut.regA.out, 8'd5);

      // MOV A,5; SHL A,A
      fill_nop();
      prog[0] = ins(7'h02, 8'd5);
      prog[1] = ins(7'h0C, 8'd0);
      start_prog();
      step();
      check8("shl_e1_a", dut.regA.out, 8'd5);
      step();
      check8("shl_e2_a", dut.regA.out, 8'd10);

      // MOV A,77; MOV (16),A; MOV A,0; MOV A,(16)
      fill_nop();
      prog[0] = ins(7'h02, 8'd77);
      prog[1] = ins(7'h0F, 8'd16);
      prog[2] = ins(7'h02, 8'd0);
      prog[3] = ins(7'h0E, 8'd16);
      start_prog();
      step();
      step();
      check8("dir_store_mem16", dut.DM.mem[16], 8'd77);
      step();
      check8("dir_clear_a", dut.regA.out, 8'd0);
      step();
      check8("dir_load_a", dut.regA.out, 8'd77);

      // Reset mid-program, with a store pending at the current PC.
      clear_dm();
      fill_nop();
      prog[0] = ins(7'h02, 8'd9);
      prog[1] = ins(7'h0F, 8'd20);
      prog[2] = ins(7'h03, 8'd8);
      prog[3] = ins(7'h0F, 8'd21);
      start_prog();
      step();
      step();
      step();
      check8("pre_reset_pc", dut.pc_out_bus, 8'd3);
      rst_n = 1'b0;
      step();
      check8("mid_reset_pc", dut.pc_out_bus, 8'd0);
      check8("mid_reset_a", dut.regA.out, 8'd0);
      check8("mid_reset_b", dut.regB.out, 8'd0);
      check8("mid_reset_no_store", dut.DM.mem[21], 8'd0);
      check8("mid_reset_dm_kept", dut.DM.mem[20], 8'd9);
      step();
      check8("held_reset_no_load_a", dut.regA.out, 8'd0);
      check8("held_reset_im_kept", {1'b0, dut.IM.mem[0][14:8]}, 8'h02);
      rst_n = 1'b1;
      step();
      check8("restart_a", dut.regA.out, 8'd9);
      check8("restart_pc", dut.pc_out_bus, 8'd1);

      // Unused opcodes: only PC moves; PC wraps 255 -> 0.
      clear_dm();
      fill_nop();
      for (int i = 2; i < 256; i++) prog[i] = ins(7'h7F, 8'($urandom_range(0, 255)));
      prog[0] = ins(7'h02, 8'h5C);
      prog[1] = ins(7'h03, 8'hA3);
      start_prog();
      for (int i = 0; i < 255; i++) step();
      check8("nop_pc_255", dut.pc_out_bus, 8'd255);
      check8("nop_a_kept", dut.regA.out, 8'h5C);
      check8("nop_b_kept", dut.regB.out, 8'hA3);
      step();
      check8("nop_pc_wrap", dut.pc_out_bus, 8'd0);
      dm_dirty = 8'd0;
      for (int i = 0; i < 256; i++) if (dut.DM.mem[i] != 8'd0) dm_dirty = 8'd1;
      check8("nop_dm_untouched", dm_dirty, 8'd0);

      // Table: preload A and B, then one instruction under test.
      for (int v = 0; v < 16; v++) begin
         fill_nop();
         prog[0] = ins(7'h02, vecs[v].a_in);
         prog[1] = ins(7'h03, vecs[v].b_in);
         prog[2] = vecs[v].instr;
         start_prog();
         step();
         step();
         step();
         check8($sformatf("vec%0d_a", v), dut.regA.out, vecs[v].exp_a);
         check8($sformatf("vec%0d_b", v), dut.regB.out, vecs[v].exp_b);
         check8($sformatf("vec%0d_pc", v), dut.pc_out_bus, 8'd3);
      end

      // Random programs against the instruction-level model.
      for (int round = 0; round < 4; round++) begin
         clear_dm();
         fill_nop();
         for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(0, 19));
            op = (r < 16) ? 7'(r) : ((r < 18) ? 7'h7F : 7'(r + 16));
            lit = 8'($urandom_range(0, 255));
            if (op == 7'h0E || op == 7'h0F) lit = 8'($urandom_range(0, 7));
            prog[i] = ins(op, lit);
         end
         start_prog();
         for (int c = 0; c < 80; c++) begin
            model_step();
            exp_q.push_back({m_pc, m_a, m_b});
            step();
            e = exp_q.pop_front();
            check8($sformatf("rnd%0d_c%0d_pc", round, c), dut.pc_out_bus, e[23:16]);
            check8($sformatf("rnd%0d_c%0d_a", round, c), dut.regA.out, e[15:8]);
            check8($sformatf("rnd%0d_c%0d_b", round, c), dut.regB.out, e[7:0]);
         end
         for (int i = 0; i < 8; i++)
            check8($sformatf("rnd%0d_dm%0d", round, i), dut.DM.mem[i], m_dm[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
